// File: rtl/sm83_irq_pkg.sv
// Shared types and constants for the sm83 interrupt controller.
package sm83_irq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DISP = 1'b1
    } disp_state_t;

    localparam int unsigned DISP_CYCLES    = 5;
    localparam int unsigned DISP_M_W       = 3;
    localparam int unsigned IDX_W          = 4;
    localparam logic [7:0]  DEF_VEC_BASE   = 8'h40;
    localparam int unsigned DEF_VEC_STRIDE = 8;

endpackage

// File: rtl/sm83_prio_enc.sv
// Lowest-index-first priority encoder over the pending interrupt mask.
module sm83_prio_enc
    import sm83_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQS = 8
) (
    input  logic [NUM_IRQS-1:0] req,
    output logic                any,
    output logic [NUM_IRQS-1:0] grant,
    output logic [IDX_W-1:0]    idx
);

    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_IRQS); i++) begin
            if (req[i] && !any) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sm83_irq_ctl.sv
// Interrupt controller: IF/IE/IME state, EI delay, and the 5-M-cycle dispatch
// sequence with vector resolution late in the dispatch.
module sm83_irq_ctl
    import sm83_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQS    = 8,
    parameter bit          EDGE_DETECT = 1'b1,
    parameter logic [7:0]  VEC_BASE    = DEF_VEC_BASE,
    parameter int unsigned VEC_STRIDE  = DEF_VEC_STRIDE
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                m_tick,
    input  logic                fetch,
    input  logic [NUM_IRQS-1:0] irq,
    input  logic                if_we,
    input  logic                ie_we,
    input  logic [NUM_IRQS-1:0] wdata,
    output logic [NUM_IRQS-1:0] if_q,
    output logic [NUM_IRQS-1:0] ie_q,
    input  logic                ei,
    input  logic                di,
    input  logic                reti,
    output logic                ime_q,
    output logic                wake,
    output logic                int_req,
    input  logic                dispatch,
    output logic [2:0]          disp_m,
    output logic                busy,
    output logic [7:0]          vector,
    output logic                vector_valid,
    output logic [NUM_IRQS-1:0] iack
);

    localparam logic [DISP_M_W-1:0] LAST_M    = DISP_M_W'(DISP_CYCLES - 1);
    localparam logic [DISP_M_W-1:0] RESOLVE_M = DISP_M_W'(DISP_CYCLES - 2);

    logic [NUM_IRQS-1:0] if_r, ie_r, irq_d, iack_r;
    logic [NUM_IRQS-1:0] if_n, iack_n, req_set, pending, grant;
    logic                ime_r, ime_pend, ime_n, pend_n;
    logic                any, accept;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          vector_r, vector_n, vec_calc;
    logic                vv_r, vv_n;
    logic [DISP_M_W-1:0] disp_m_r, disp_m_n;
    disp_state_t         state, state_n;

    assign pending = if_r & ie_r;

    sm83_prio_enc #(.NUM_IRQS(NUM_IRQS)) u_prio (
        .req   (pending),
        .any   (any),
        .grant (grant),
        .idx   (idx)
    );

    assign wake     = any;
    assign int_req  = ime_r & any & (state == IDLE);
    assign accept   = dispatch & int_req;
    assign req_set  = EDGE_DETECT ? (irq & ~irq_d) : irq;
    assign vec_calc = VEC_BASE + 8'(32'(idx) * VEC_STRIDE);

    // Per-bit IF update: request set beats acknowledge clear beats software write.
    always_comb begin
        if_n = if_r;
        for (int i = 0; i < int'(NUM_IRQS); i++) begin
            if (req_set[i])      if_n[i] = 1'b1;
            else if (iack_n[i])  if_n[i] = 1'b0;
            else if (if_we)      if_n[i] = wdata[i];
        end
    end

    // Later assignments win: di overrides everything, dispatch acceptance clears IME.
    always_comb begin
        ime_n  = ime_r;
        pend_n = ime_pend;
        if (fetch && ime_pend) begin
            ime_n  = 1'b1;
            pend_n = 1'b0;
        end
        if (ei)     pend_n = 1'b1;
        if (reti)   ime_n  = 1'b1;
        if (accept) ime_n  = 1'b0;
        if (di) begin
            ime_n  = 1'b0;
            pend_n = 1'b0;
        end
    end

    // Dispatch sequencer; the vector is picked at the end of the high-byte push.
    always_comb begin
        state_n  = state;
        disp_m_n = disp_m_r;
        vector_n = vector_r;
        vv_n     = vv_r;
        iack_n   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n  = DISP;
                    disp_m_n = '0;
                end
            end
            DISP: begin
                if (m_tick) begin
                    if (disp_m_r == LAST_M) begin
                        state_n  = IDLE;
                        disp_m_n = '0;
                        vv_n     = 1'b0;
                    end else begin
                        disp_m_n = disp_m_r + DISP_M_W'(1);
                        if (disp_m_r == RESOLVE_M) begin
                            vector_n = any ? vec_calc : 8'h00;
                            iack_n   = grant;
                            vv_n     = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            if_r     <= '0;
            ie_r     <= '0;
            irq_d    <= '0;
            ime_r    <= 1'b0;
            ime_pend <= 1'b0;
        end else begin
            if_r     <= if_n;
            irq_d    <= irq;
            ime_r    <= ime_n;
            ime_pend <= pend_n;
            if (ie_we) ie_r <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            disp_m_r <= '0;
            vector_r <= 8'h00;
            vv_r     <= 1'b0;
            iack_r   <= '0;
        end else begin
            state    <= state_n;
            disp_m_r <= disp_m_n;
            vector_r <= vector_n;
            vv_r     <= vv_n;
            iack_r   <= iack_n;
        end
    end

    assign if_q         = if_r;
    assign ie_q         = ie_r;
    assign ime_q        = ime_r;
    assign busy         = (state == DISP);
    assign disp_m       = disp_m_r;
    assign vector       = vector_r;
    assign vector_valid = vv_r;
    assign iack         = iack_r;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Bench for sm83_irq_ctl: edge-mode instance against a rule-level model with a
// resolution scoreboard, plus a level-mode 12-channel instance with directed checks.
module tb_sm83_irq_ctl;

    localparam int unsigned N           = 8;
    localparam int unsigned NB          = 12;
    localparam int unsigned RAND_CYCLES = 4000;

    logic clk     = 1'b0;
    logic n_reset = 1'b0;

    logic         m_tick = 1'b0, fetch = 1'b0, if_we = 1'b0, ie_we = 1'b0;
    logic         ei = 1'b0, di = 1'b0, reti = 1'b0, dispatch = 1'b0;
    logic [N-1:0] irq = '0, wdata = '0;
    logic [N-1:0] if_q, ie_q, iack;
    logic         ime_q, wake, int_req, busy, vector_valid;
    logic [2:0]   disp_m;
    logic [7:0]   vector;

    logic          b_m_tick = 1'b0, b_fetch = 1'b0, b_if_we = 1'b0, b_ie_we = 1'b0;
    logic          b_ei = 1'b0, b_di = 1'b0, b_reti = 1'b0, b_dispatch = 1'b0;
    logic [NB-1:0] b_irq = '0, b_wdata = '0;
    logic [NB-1:0] b_if_q, b_ie_q, b_iack;
    logic          b_ime_q, b_wake, b_int_req, b_busy, b_vector_valid;
    logic [2:0]    b_disp_m;
    logic [7:0]    b_vector;

    always #5 clk = ~clk;

    sm83_irq_ctl #(.NUM_IRQS(N), .EDGE_DETECT(1'b1), .VEC_BASE(8'h40), .VEC_STRIDE(8)) u_dut (
        .clk(clk), .n_reset(n_reset), .m_tick(m_tick), .fetch(fetch), .irq(irq),
        .if_we(if_we), .ie_we(ie_we), .wdata(wdata), .if_q(if_q), .ie_q(ie_q),
        .ei(ei), .di(di), .reti(reti), .ime_q(ime_q), .wake(wake), .int_req(int_req),
        .dispatch(dispatch), .disp_m(disp_m), .busy(busy), .vector(vector),
        .vector_valid(vector_valid), .iack(iack)
    );

    sm83_irq_ctl #(.NUM_IRQS(NB), .EDGE_DETECT(1'b0), .VEC_BASE(8'h40), .VEC_STRIDE(8)) u_dut_lvl (
        .clk(clk), .n_reset(n_reset), .m_tick(b_m_tick), .fetch(b_fetch), .irq(b_irq),
        .if_we(b_if_we), .ie_we(b_ie_we), .wdata(b_wdata), .if_q(b_if_q), .ie_q(b_ie_q),
        .ei(b_ei), .di(b_di), .reti(b_reti), .ime_q(b_ime_q), .wake(b_wake), .int_req(b_int_req),
        .dispatch(b_dispatch), .disp_m(b_disp_m), .busy(b_busy), .vector(b_vector),
        .vector_valid(b_vector_valid), .iack(b_iack)
    );

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit vv_seen = 1'b0;

    // Reference model state, expressed as the architectural rules.
    logic [7:0] m_if = '0, m_ie = '0, m_irq_prev = '0, m_iack = '0;
    bit         m_ime = 1'b0, m_pend = 1'b0, m_busy = 1'b0, m_vv = 1'b0;
    int         m_ticks = 0;

    typedef struct packed {
        logic [7:0] vec;
        logic [7:0] ack;
    } evt_t;
    evt_t evt_q[$];

    typedef struct packed {
        logic [7:0] ifr;
        logic [7:0] ier;
        logic       ime;
        logic       req;
        logic       wk;
        logic       bsy;
        logic [2:0] dm;
        logic       vv;
        logic [7:0] ack;
    } snap_t;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_if = '0; m_ie = '0; m_irq_prev = '0; m_iack = '0;
        m_ime = 1'b0; m_pend = 1'b0; m_busy = 1'b0; m_vv = 1'b0; m_ticks = 0;
        evt_q.delete();
    endtask

    task automatic model_step();
        logic [7:0] pend, clr, nif;
        int         lo;
        bit         acc, res, ime_n, pend_n;
        evt_t       e;
        pend = m_if & m_ie;
        lo   = lowest(pend);
        acc  = dispatch && m_ime && (pend != 8'h00) && !m_busy;
        res  = m_busy && m_tick && (m_ticks == 3);
        clr  = '0;
        if (res && lo >= 0) clr[lo] = 1'b1;
        nif = (irq & ~m_irq_prev) | (~clr & (if_we ? wdata : m_if));
        ime_n  = m_ime;
        pend_n = m_pend;
        if (di) begin
            ime_n  = 1'b0;
            pend_n = 1'b0;
        end else begin
            if (acc) ime_n = 1'b0;
            else if (reti || (fetch && m_pend)) ime_n = 1'b1;
            if (ei) pend_n = 1'b1;
            else if (fetch && m_pend) pend_n = 1'b0;
        end
        if (res) begin
            e.vec = (lo < 0) ? 8'h00 : 8'((64 + lo * 8) % 256);
            e.ack = clr;
            evt_q.push_back(e);
        end
        m_iack = clr;
        if (acc) begin
            m_busy  = 1'b1;
            m_ticks = 0;
        end else if (m_busy && m_tick) begin
            if (m_ticks == 4) begin
                m_busy = 1'b0; m_ticks = 0; m_vv = 1'b0;
            end else begin
                if (m_ticks == 3) m_vv = 1'b1;
                m_ticks++;
            end
        end
        m_if = nif;
        if (ie_we) m_ie = wdata;
        m_ime      = ime_n;
        m_pend     = pend_n;
        m_irq_prev = irq;
    endtask

    initial forever begin
        @(posedge clk or negedge n_reset);
        if (!n_reset) model_reset();
        else model_step();
    end

    // Monitor: per-cycle architectural state and popped resolution events.
    initial forever begin
        snap_t exp_s, act_s;
        evt_t  e;
        @(negedge clk);
        if (mon_en) begin
            exp_s = '{ifr: m_if, ier: m_ie, ime: m_ime,
                      req: m_ime && ((m_if & m_ie) != 8'h00) && !m_busy,
                      wk: (m_if & m_ie) != 8'h00, bsy: m_busy,
                      dm: m_busy ? 3'(m_ticks) : 3'd0, vv: m_vv, ack: m_iack};
            act_s = '{ifr: if_q, ier: ie_q, ime: ime_q, req: int_req, wk: wake,
                      bsy: busy, dm: disp_m, vv: vector_valid, ack: iack};
            n_vec++;
            if (act_s !== exp_s) begin
                n_err++;
                $display("FAIL cycle_state t=%0t got %h expected %h", $time, act_s, exp_s);
            end
            if (vector_valid && !vv_seen) begin
                n_vec++;
                if (evt_q.size() == 0) begin
                    n_err++;
                    $display("FAIL resolve_unexpected t=%0t got vector=%h iack=%h expected none", $time, vector, iack);
                end else begin
                    e = evt_q.pop_front();
                    if ({vector, iack} !== {e.vec, e.ack}) begin
                        n_err++;
                        $display("FAIL resolve t=%0t got vector=%h iack=%h expected vector=%h iack=%h",
                                 $time, vector, iack, e.vec, e.ack);
                    end
                end
            end
            vv_seen = vector_valid;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        m_tick = 1'b0; fetch = 1'b0; if_we = 1'b0; ie_we = 1'b0;
        ei = 1'b0; di = 1'b0; reti = 1'b0; dispatch = 1'b0;
        b_m_tick = 1'b0; b_fetch = 1'b0; b_if_we = 1'b0; b_ie_we = 1'b0;
        b_ei = 1'b0; b_di = 1'b0; b_reti = 1'b0; b_dispatch = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            m_tick = 1'b1;
            cycle();
        end
    endtask

    initial begin
        // Reset held with all requests high
        irq = 8'hFF;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_if", 32'(if_q), 32'h0);
        chk("reset_ime", 32'(ime_q), 32'h0);
        chk("reset_int_req", 32'(int_req), 32'h0);
        chk("reset_disp_m", 32'(disp_m), 32'h0);
        chk("reset_vv", 32'(vector_valid), 32'h0);
        irq = 8'h00;
        n_reset = 1'b1;
        mon_en  = 1'b1;
        cycle();
        chk("post_reset_if", 32'(if_q), 32'h0);
        irq = 8'h04;
        cycle();
        chk("first_edge_if", 32'(if_q), 32'h04);
        irq = 8'h00;

        // EI delay
        irq = 8'h01; wdata = 8'h01; ie_we = 1'b1;
        cycle();
        ei = 1'b1;
        cycle();
        chk("ei_no_req_1", 32'(int_req), 32'h0);
        cycle();
        chk("ei_no_req_2", 32'(int_req), 32'h0);
        fetch = 1'b1;
        cycle();
        chk("ei_fetch_ime", 32'(ime_q), 32'h1);
        chk("ei_fetch_req", 32'(int_req), 32'h1);
        di = 1'b1;
        cycle();
        ei = 1'b1; cycle();
        di = 1'b1; cycle();
        fetch = 1'b1; cycle();
        chk("ei_di_fetch_ime", 32'(ime_q), 32'h0);

        // Priority and dispatch
        irq = 8'h00; wdata = 8'h1F; ie_we = 1'b1;
        cycle();
        wdata = 8'h14; if_we = 1'b1;
        cycle();
        reti = 1'b1;
        cycle();
        chk("reti_req", 32'(int_req), 32'h1);
        dispatch = 1'b1;
        cycle();
        chk("disp_ime", 32'(ime_q), 32'h0);
        chk("disp_busy", 32'(busy), 32'h1);
        ticks(4);
        chk("disp_vector", 32'(vector), 32'h50);
        chk("disp_iack", 32'(iack), 32'h04);
        chk("disp_if", 32'(if_q), 32'h10);
        cycle();
        chk("iack_one_clk", 32'(iack), 32'h0);
        ticks(1);
        chk("disp_end_busy", 32'(busy), 32'h0);

        // Cancellation by an IE write mid-dispatch
        reti = 1'b1; cycle();
        dispatch = 1'b1; cycle();
        ticks(2);
        wdata = 8'h00; ie_we = 1'b1;
        cycle();
        ticks(2);
        chk("cancel_vector", 32'(vector), 32'h00);
        chk("cancel_vv", 32'(vector_valid), 32'h1);
        chk("cancel_iack", 32'(iack), 32'h0);
        chk("cancel_if", 32'(if_q), 32'h10);
        ticks(1);

        // Async reset mid-dispatch
        wdata = 8'h1F; ie_we = 1'b1; cycle();
        reti = 1'b1; cycle();
        dispatch = 1'b1; cycle();
        ticks(3);
        chk("pre_reset_disp_m", 32'(disp_m), 32'h3);
        n_reset = 1'b0;
        #2;
        chk("mid_reset_busy", 32'(busy), 32'h0);
        chk("mid_reset_disp_m", 32'(disp_m), 32'h0);
        n_reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_tick = 1'b1;
            cycle();
            chk("mid_reset_no_iack", 32'(iack), 32'h0);
        end

        // Randomized traffic checked by the model
        for (int c = 0; c < int'(RAND_CYCLES); c++) begin
            int r;
            if ($urandom_range(0, 5) == 0) irq = 8'($urandom) & 8'($urandom);
            m_tick   = ($urandom_range(0, 2) == 0);
            fetch    = ($urandom_range(0, 3) == 0);
            dispatch = ($urandom_range(0, 2) == 0);
            if_we    = ($urandom_range(0, 29) == 0);
            ie_we    = ($urandom_range(0, 19) == 0);
            wdata    = 8'($urandom);
            r = int'($urandom_range(0, 99));
            ei   = (r < 10);
            di   = (r >= 10 && r < 13);
            reti = (r >= 13 && r < 16);
            cycle();
        end
        cycle();
        cycle();

        // Level mode, 12 channels, HALT wake with IME=0
        b_wdata = 12'h800; b_ie_we = 1'b1;
        cycle();
        b_irq = 12'h800;
        cycle();
        chk("lvl_if", 32'(b_if_q), 32'h800);
        chk("lvl_wake", 32'(b_wake), 32'h1);
        chk("lvl_no_req", 32'(b_int_req), 32'h0);
        b_wdata = 12'h000; b_if_we = 1'b1;
        cycle();
        chk("lvl_set_beats_write", 32'(b_if_q), 32'h800);
        b_reti = 1'b1;
        cycle();
        chk("lvl_req", 32'(b_int_req), 32'h1);
        b_dispatch = 1'b1;
        cycle();
        chk("lvl_busy", 32'(b_busy), 32'h1);
        for (int k = 0; k < 4; k++) begin
            b_m_tick = 1'b1;
            cycle();
        end
        chk("lvl_vector", 32'(b_vector), 32'h98);
        chk("lvl_iack", 32'(b_iack), 32'h800);
        chk("lvl_set_beats_iack", 32'(b_if_q), 32'h800);
        b_irq = 12'h000; b_wdata = 12'h000; b_if_we = 1'b1; b_m_tick = 1'b1;
        cycle();
        chk("lvl_cleared_if", 32'(b_if_q), 32'h0);
        chk("lvl_no_wake", 32'(b_wake), 32'h0);
        chk("lvl_idle", 32'(b_busy), 32'h0);

        chk("evt_q_drained", 32'(evt_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctl.md
# sm83_irq_ctl

Parametrised interrupt controller for the sm83 core. It replaces the fixed 8-line `irq`/`iack` pair with a configurable number of channels and an optional edge-detect mode. It owns the IF, IE and IME state, the delayed enable after EI and HALT wake-up, and the 5-M-cycle dispatch sequence, including late vector resolution. It sits between the peripheral request lines and `sm83_control`, which sees only `int_req`, `dispatch` and the resolved vector.

## Interface
- `NUM_IRQS`, 8: number of request channels (1..16).
- `EDGE_DETECT`, 1: 1 sets an IF bit on a rising edge of `irq`; 0 sets it while `irq` is high (level).
- `VEC_BASE`, 8'h40: vector of channel 0.
- `VEC_STRIDE`, 8: vector spacing between channels.

Ports:
- `clk`  in  1  core clock.
- `n_reset`  in  1  asynchronous, active-low reset.
- `m_tick`  in  1  one-`clk` strobe marking the end of each M-cycle.
- `fetch`  in  1  one-`clk` strobe at the opcode-fetch M-cycle boundary.
- `irq`  in  NUM_IRQS  request lines, synchronous to `clk`.
- `if_we`, `ie_we`  in  1  software writes to IF/IE.
- `wdata`  in  NUM_IRQS  write data.
- `if_q`, `ie_q`  out  NUM_IRQS  current IF/IE.
- `ei`, `di`, `reti`  in  1  one-`clk` instruction strobes.
- `ime_q`  out  1  current IME.
- `wake`  out  1  |(IF & IE); asserted regardless of IME.
- `int_req`  out  1  IME && |(IF & IE) && state IDLE.
- `dispatch`  in  1  control accepts the interrupt; valid only while `int_req` is high.
- `disp_m`  out  3  dispatch M-cycle index 0..4; 0 when idle.
- `busy`  out  1  dispatch in progress.
- `vector`  out  8  low byte of the target address; the high byte is always 0.
- `vector_valid`  out  1  vector is resolved.
- `iack`  out  NUM_IRQS  one-hot, one-`clk` acknowledge pulse.

## Operation
- **Reset values.** IF=0, IE=0, IME=0, ime_pend=0, state IDLE, disp_m=0. `iack`=0, `vector`=0, `vector_valid`=0, `int_req`=0.
- **IF update per bit, per `clk`, highest priority first:**
  1. Request set: rising edge of `irq` (edge mode) or `irq` high (level mode). The edge detector register resets to 0.
  2. `iack` clear.
  3. `if_we` loads `wdata`.
  4. Otherwise hold.
- **IE** loads `wdata` on `ie_we`.
- **IME rules:**
  - `di` clears IME and ime_pend.
  - `ei` sets ime_pend only.
  - On `fetch` with ime_pend set, IME is set and ime_pend is cleared. The instruction after EI therefore always completes before any dispatch.
  - `reti` sets IME immediately.
  - `ei` then `di` before `fetch` leaves IME=0.
  - If `di` and `fetch` fall on the same `clk`, `di` wins.
- **Priority.** The lowest set index of IF & IE wins.
- **State machine:**
  - IDLE→DISP on `dispatch` while `int_req` is high. IME clears on the same edge. `dispatch` while `int_req` is low is ignored.
  - In DISP, `disp_m` increments on each `m_tick`.
  - At the `m_tick` that ends `disp_m`=3 (the high-byte push), IF & IE is re-evaluated:
    - Non-zero: `vector` = VEC_BASE + idx*VEC_STRIDE (mod 256), and `iack`[idx] pulses.
    - Zero (cancelled by a write during dispatch): `vector` = 0x00 and no `iack` pulse.
  - `vector_valid` is high throughout `disp_m`=4.
  - The `m_tick` ending `disp_m`=4 returns the state to IDLE.
- **HALT.** `wake` is combinational from IF & IE, so HALT exits even when IME=0.
- **Reset mid-dispatch.** Everything returns to reset values asynchronously, and no `iack` is emitted.

## Timing
- Edge mode: an `irq` rising edge at clk edge N sets IF at N+1. `int_req` is high at N+1 if IME=1 and IE is set.
- `dispatch`→`busy`: 1 `clk`.
- `vector`/`vector_valid`/`iack`: registered on the `m_tick` ending `disp_m`=3. `iack` lasts exactly 1 `clk`.
- Dispatch length: exactly 5 `m_tick`s; `m_tick`s outside DISP do not advance `disp_m`.
- `wake` and `int_req`: combinational from registered state, with no input-to-output path other than through registers.

## Structure
- **Package `sm83_irq_pkg`:** `disp_state_t` enum (IDLE, DISP), `DISP_CYCLES` = 5, default `VEC_BASE`/`VEC_STRIDE`.
- **Sub-module `sm83_prio_enc`:** parametrised on `NUM_IRQS`, combinational, lowest-index-first. Outputs `any`, the one-hot grant and the binary index. It is shared by the `int_req` path and the vector resolution at `disp_m`=3.
- **Widths:** IF/IE are `logic [NUM_IRQS-1:0]`. The vector arithmetic is done in 8 bits and wraps silently.

## Test plan
- **Reset:** hold `n_reset`=0 with `irq`=8'hFF; release it → IF=0, IME=0, `int_req`=0; first edge at `irq`[2] → IF=8'h04.
- **EI delay:** IE=8'h01, IF[0]=1, pulse `ei` → `int_req` stays 0 until `fetch`, then rises; `ei`,`di`,`fetch` → IME stays 0.
- **Priority and dispatch:** IME=1, IE=8'h1F, IF=8'h14, assert `dispatch` → IME=0; after 4 `m_tick`s `vector`=8'h50, `iack`=8'h04 for 1 `clk`, IF=8'h10; the 5th `m_tick` returns to idle.
- **Cancellation:** during dispatch `disp_m`=2, write IE=0 → `vector`=8'h00, no `iack`, IF unchanged.
- **Level mode and HALT:** `EDGE_DETECT`=0, `NUM_IRQS`=12, IME=0, IE[11]=1, `irq`[11] high → `wake`=1, `int_req`=0; `if_we` clears IF while `irq`[11] is still high → IF[11] stays 1.
- **Async reset mid-dispatch:** pulse `n_reset` low at `disp_m`=3 → `busy`=0, `disp_m`=0, no `iack`.
